// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one byte per strobe, shifted out LSB first as start/data/[parity]/stop,
// one bit per UART_TX_CLK cycle. Define UART_TX_PARITY_EN to add the parity bit and UART_TX_PAR_TYP port.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  UART_TX_CLK,
   input  logic                  UART_TX_RST,
   input  logic [DATA_WIDTH-1:0] UART_TX_P_DATA,
   input  logic                  UART_TX_Data_Valid,
`ifdef UART_TX_PARITY_EN
   input  logic                  UART_TX_PAR_TYP,
`endif
   output logic                  UART_TX_OUT,
   output logic                  UART_TX_Busy
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                r_state;
   logic                  r_out;
   logic                  r_busy;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_shift;
`ifdef UART_TX_PARITY_EN
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_parTyp;
`endif

   // The state names the bit currently on the line; each edge loads the next bit into r_out.
   always_ff @(posedge UART_TX_CLK) begin
      if (!UART_TX_RST) begin
         r_state  <= IDLE;
         r_out    <= 1'b1;
         r_busy   <= 1'b0;
         r_count  <= '0;
         r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
         r_data   <= '0;
         r_parTyp <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_out  <= 1'b1;
               r_busy <= 1'b0;
               if (UART_TX_Data_Valid) begin
                  r_shift  <= UART_TX_P_DATA;
`ifdef UART_TX_PARITY_EN
                  r_data   <= UART_TX_P_DATA;
                  r_parTyp <= UART_TX_PAR_TYP;
`endif
                  r_count  <= '0;
                  r_out    <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= START;
               end
            end
            START: begin
               r_out   <= r_shift[0];
               r_shift <= r_shift >> 1;
               r_count <= r_count + CW'(1);
               r_state <= DATA;
            end
            DATA: begin
               // r_count is the number of data bits already placed on the line.
               if (r_count == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  r_out   <= r_parTyp ? ~^r_data : ^r_data;
                  r_state <= PARITY;
`else
                  r_out   <= 1'b1;
                  r_state <= STOP;
`endif
               end else begin
                  r_out   <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_count <= r_count + CW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               r_out   <= 1'b1;
               r_state <= STOP;
            end
`endif
            STOP: begin
               r_out   <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_out   <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign UART_TX_OUT  = r_out;
   assign UART_TX_Busy = r_busy;

endmodule
